alu_pwr_seq: RTL

//  Power-sequencing controller for the switchable ALU domain; the driving end of the ALU's alu_pwr_en/iso_en interface.

---
 rtl/alu_pwr_seq_if.sv | 23 ++
 rtl/alu_pwr_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq_if.sv
// Signal bundle between the always-on power sequencer (master) and the ALU wrapper (slave).
interface alu_pwr_seq_if;
  logic       pd_req;
  logic       pu_req;
  logic       alu_busy;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_rst_n;
  logic       pd_ack;
  logic       pu_ack;
  logic       err;
  logic [2:0] pwr_state;

  modport master (
    input  pd_req, pu_req, alu_busy,
    output alu_pwr_en, iso_en, alu_rst_n, pd_ack, pu_ack, err, pwr_state
  );

  modport slave (
    output pd_req, pu_req, alu_busy,
    input  alu_pwr_en, iso_en, alu_rst_n, pd_ack, pu_ack, err, pwr_state
  );
endinterface

// File: rtl/alu_pwr_seq.sv
// ALU power-domain sequencer: orders isolation, supply enable and domain reset.
// Optional build macro PWR_DRAIN_TIMEOUT_EN: a DRAIN stuck on alu_busy aborts back to ON with an err pulse.
//
// state  | meaning
// OFF    | supply off, isolated, domain in reset; waits for pu_req
// ON     | domain powered and running; waits for pd_req
// DRAIN  | waiting for alu_busy to fall before isolating
// ISO    | isolation applied, supply still on (ISO_SETUP cycles)
// PWRUP  | supply on, domain reset held (PWR_SETTLE cycles)
// RSTREL | reset released, isolation still held (RST_HOLD cycles)
module alu_pwr_seq #(
  parameter int ISO_SETUP  = 2,
  parameter int PWR_SETTLE = 4,
  parameter int RST_HOLD   = 2,
  parameter int DRAIN_MAX  = 16,
  parameter int CNT_W      = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_pwr_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ON     = 3'd1,
    S_DRAIN  = 3'd2,
    S_ISO    = 3'd3,
    S_PWRUP  = 3'd4,
    S_RSTREL = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LD_ISO    = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP  = CNT_W'(PWR_SETTLE - 1);
  localparam logic [CNT_W-1:0] LD_RSTREL = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_DRAIN  = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             pd_ack_nxt, pu_ack_nxt, err_nxt;

  // {alu_pwr_en, iso_en, alu_rst_n}; unknown codes decode as OFF so isolation is safe
  function automatic logic [2:0] drive(input state_t s);
    case (s)
      S_ON, S_DRAIN: drive = 3'b101;
      S_ISO:         drive = 3'b111;
      S_PWRUP:       drive = 3'b110;
      S_RSTREL:      drive = 3'b111;
      default:       drive = 3'b010;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    pd_ack_nxt = 1'b0;
    pu_ack_nxt = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      S_OFF: begin
        if (bus.pu_req) begin
          state_nxt = S_PWRUP;
          timer_nxt = LD_PWRUP;
        end
      end
      S_ON: begin
        if (bus.pd_req) begin
          state_nxt = S_DRAIN;
          timer_nxt = LD_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.alu_busy) begin
          state_nxt = S_ISO;
          timer_nxt = LD_ISO;
        end
`ifdef PWR_DRAIN_TIMEOUT_EN
        else if (timer == '0) begin
          state_nxt = S_ON;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer - CNT_ONE;
        end
`endif
      end
      S_ISO: begin
        if (timer == '0) begin
          state_nxt  = S_OFF;
          pd_ack_nxt = 1'b1;
        end else begin
          timer_nxt = timer - CNT_ONE;
        end
      end
      S_PWRUP: begin
        if (timer == '0) begin
          state_nxt = S_RSTREL;
          timer_nxt = LD_RSTREL;
        end else begin
          timer_nxt = timer - CNT_ONE;
        end
      end
      S_RSTREL: begin
        if (timer == '0) begin
          state_nxt  = S_ON;
          pu_ack_nxt = 1'b1;
        end else begin
          timer_nxt = timer - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_OFF;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they always match the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                                       <= S_OFF;
      timer                                       <= '0;
      {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b010;
      bus.pd_ack                                  <= 1'b0;
      bus.pu_ack                                  <= 1'b0;
      bus.err                                     <= 1'b0;
    end else begin
      state                                       <= state_nxt;
      timer                                       <= timer_nxt;
      {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= drive(state_nxt);
      bus.pd_ack                                  <= pd_ack_nxt;
      bus.pu_ack                                  <= pu_ack_nxt;
      bus.err                                     <= err_nxt;
    end
  end

  assign bus.pwr_state = state;

endmodule
